// File: rtl/counter_tick_datapath.sv
// Purpose: prescaled up/down modulo counter driven by run/clear/mode levels from the controller.
// Latency: all outputs registered; first count update on the DIV-th enabled edge after the prescaler is at 0.
// Backpressure: none; pause (i_enable=0) holds count and prescaler phase, clear forces both to 0.
module counter_tick_datapath #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_COUNT = 10000,
    localparam int DIV      = CLK_FREQ / TICK_HZ,
    localparam int CW       = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_enable,
    input  logic          i_clear,
    input  logic          i_mode,
    output logic [CW-1:0] o_count,
    output logic          o_tick,
    output logic          o_wrap
);

    // Prescaler needs at least one bit even when every enabled edge is an update edge.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    // A tick rate faster than the clock or an empty count range cannot be built.
    if (DIV < 1) begin : g_bad_div
        $error("counter_tick_datapath: CLK_FREQ/TICK_HZ must be >= 1");
    end
    if (MAX_COUNT < 1) begin : g_bad_max
        $error("counter_tick_datapath: MAX_COUNT must be >= 1");
    end

    logic [PW-1:0] p_q, p_d;
    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;

    // Next state: clear beats run beats hold; pulses default low every cycle.
    always_comb begin
        p_d     = p_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (i_clear) begin
            p_d     = '0;
            count_d = '0;
        end else if (i_enable) begin
            if (p_q == P_LAST) begin
                // Update edge: mode is only looked at here, so mid-period changes wait for it.
                p_d    = '0;
                tick_d = 1'b1;
                if (i_mode) begin
                    if (count_q == CNT_ZERO) begin
                        count_d = CNT_LAST;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end else begin
                    if (count_q == CNT_LAST) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end else begin
                p_d = p_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; a pending tick does not survive reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p_q     <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_count = count_q;
    assign o_tick  = tick_q;
    assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_counter_tick_datapath.sv
// Bench for counter_tick_datapath: a DIV=10/MAX=10000 instance for period, pause, clear and reset
// sequences, and a DIV=1/MAX=12 instance exercised by a per-edge vector table.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_counter_tick_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic        mode;

    logic [13:0] count_a;
    logic        tick_a;
    logic        wrap_a;
    logic [3:0]  count_b;
    logic        tick_b;
    logic        wrap_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    counter_tick_datapath #(
        .CLK_FREQ (100),
        .TICK_HZ  (10),
        .MAX_COUNT(10000)
    ) u_a (
        .clk     (clk),
        .rst     (rst),
        .i_enable(en),
        .i_clear (clr),
        .i_mode  (mode),
        .o_count (count_a),
        .o_tick  (tick_a),
        .o_wrap  (wrap_a)
    );

    counter_tick_datapath #(
        .CLK_FREQ (12),
        .TICK_HZ  (12),
        .MAX_COUNT(12)
    ) u_b (
        .clk     (clk),
        .rst     (rst),
        .i_enable(en),
        .i_clear (clr),
        .i_mode  (mode),
        .o_count (count_b),
        .o_tick  (tick_b),
        .o_wrap  (wrap_b)
    );

    typedef struct {
        logic rst;
        logic en;
        logic clr;
        logic mode;
        int   cnt;
        logic tick;
        logic wrap;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n edges with current inputs, observing unit A's pulses.
    task automatic run(input int n, output int ticks, output int wraps, output int first);
        ticks = 0;
        wraps = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (tick_a) begin
                ticks++;
                if (first == 0) first = i;
            end
            if (wrap_a) wraps++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        clr = 1'b0;
        mode = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        int tk, wr, fst, bad;

        rst = 1'b0; en = 1'b0; clr = 1'b0; mode = 1'b0;

        // Unit B (DIV=1, MAX=12): state expected after each edge.
        //            rst   en    clr   mode  cnt tick  wrap
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0,  2, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1,  0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 11, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 11, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0};

        for (int v = 0; v < 13; v++) begin
            rst  = vecs[v].rst;
            en   = vecs[v].en;
            clr  = vecs[v].clr;
            mode = vecs[v].mode;
            step();
            chk($sformatf("b_vec%0d_count", v), int'(count_b), vecs[v].cnt);
            chk($sformatf("b_vec%0d_tick", v), int'(tick_b), int'(vecs[v].tick));
            chk($sformatf("b_vec%0d_wrap", v), int'(wrap_b), int'(vecs[v].wrap));
        end

        // Unit B full up lap from 1: ten updates reach 11, the eleventh wraps to 0.
        bad = 0;
        for (int i = 2; i <= 11; i++) begin
            step();
            if (count_b != 4'(i) || !tick_b || wrap_b) bad++;
        end
        chk("b_lap_no_early_wrap", bad, 0);
        step();
        chk("b_lap_wrap_count", int'(count_b), 0);
        chk("b_lap_wrap_pulse", int'(wrap_b), 1);

        // Unit A: reset state.
        do_reset();
        chk("a_reset_count", int'(count_a), 0);
        chk("a_reset_tick", int'(tick_a), 0);
        chk("a_reset_wrap", int'(wrap_a), 0);

        // Up count for 100 edges: tick exactly on every 10th edge, count steps with it.
        en = 1'b1; mode = 1'b0;
        bad = 0; wr = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (int'(tick_a) != int'(i % 10 == 0)) bad++;
            if (int'(count_a) != i / 10) bad++;
            if (wrap_a) wr++;
        end
        chk("a_up100_pattern", bad, 0);
        chk("a_up100_count", int'(count_a), 10);
        chk("a_up100_wraps", wr, 0);

        // Down from reset wraps to 9999, then up wraps to 0, then 1 without wrap.
        do_reset();
        en = 1'b1; mode = 1'b1;
        run(10, tk, wr, fst);
        chk("a_down_first_edge", fst, 10);
        chk("a_down_count", int'(count_a), 9999);
        chk("a_down_wrap", int'(wrap_a), 1);
        run(10, tk, wr, fst);
        chk("a_down2_count", int'(count_a), 9998);
        chk("a_down2_wrap", wr, 0);
        mode = 1'b1;
        run(10, tk, wr, fst);
        mode = 1'b0;
        run(10, tk, wr, fst);
        chk("a_up_from_9998", int'(count_a), 9998);
        run(10, tk, wr, fst);
        chk("a_up_to_9999_wrap", wr, 0);
        run(10, tk, wr, fst);
        chk("a_up_wrap_count", int'(count_a), 0);
        chk("a_up_wrap_tick", int'(tick_a), 1);
        chk("a_up_wrap_pulse", int'(wrap_a), 1);
        run(10, tk, wr, fst);
        chk("a_after_wrap_count", int'(count_a), 1);
        chk("a_after_wrap_pulse", wr, 0);

        // Pause at p=5 keeps both count and phase.
        do_reset();
        en = 1'b1; mode = 1'b0;
        run(15, tk, wr, fst);
        en = 1'b0;
        mode = 1'b1;
        run(7, tk, wr, fst);
        chk("a_pause_ticks", tk, 0);
        chk("a_pause_count", int'(count_a), 1);
        en = 1'b1;
        mode = 1'b0;
        run(4, tk, wr, fst);
        chk("a_resume_no_early_tick", tk, 0);
        run(1, tk, wr, fst);
        chk("a_resume_tick", tk, 1);
        chk("a_resume_count", int'(count_a), 2);

        // Mode flips mid-period: only the mode on the update edge matters, period unchanged.
        mode = 1'b1;
        run(5, tk, wr, fst);
        mode = 1'b0;
        run(5, tk, wr, fst);
        chk("a_midmode_tick_edge", fst, 5);
        chk("a_midmode_count", int'(count_a), 3);

        // Clear on an update edge at count 37.
        do_reset();
        en = 1'b1; mode = 1'b0;
        run(379, tk, wr, fst);
        chk("a_pre_clear_count", int'(count_a), 37);
        clr = 1'b1;
        step();
        chk("a_clear_count", int'(count_a), 0);
        chk("a_clear_tick", int'(tick_a), 0);
        clr = 1'b0;
        run(10, tk, wr, fst);
        chk("a_post_clear_first", fst, 10);
        chk("a_post_clear_count", int'(count_a), 1);

        // Reset mid-period with count 3, p 7.
        do_reset();
        en = 1'b1;
        run(37, tk, wr, fst);
        chk("a_pre_rst_count", int'(count_a), 3);
        rst = 1'b0;
        step();
        chk("a_midrst_count", int'(count_a), 0);
        chk("a_midrst_tick", int'(tick_a), 0);
        rst = 1'b1;
        run(10, tk, wr, fst);
        chk("a_post_rst_first", fst, 10);
        chk("a_post_rst_count", int'(count_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
